// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_acc_pkg;

    // Accumulator width for the default configuration (IN_W=128, GUARD=8).
    localparam int unsigned ACC_W = 128 + 8;

    typedef enum logic [1:0] {
        ACC,
        RESOLVE,
        DONE
    } acc_state_t;

    function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_row.sv
// 3:2 carry-save compressor row: bitwise sum plus majority carry shifted up one bit.
module csa_row #(
    parameter int unsigned W = 136
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    // Top majority bit falls off: the accumulation is modulo 2^W.
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: redundant accumulation per beat, then a chunked
// multi-cycle carry-propagate add resolves the result under valid/ready.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned IN_W      = 128,
    parameter int unsigned NUM_IN    = 2,
    parameter int unsigned GUARD     = 8,
    parameter int unsigned CPA_CHUNK = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*IN_W-1:0]   in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IN_W+GUARD-1:0]    out_data
);

    localparam int unsigned AW   = IN_W + GUARD;
    localparam int unsigned NCH  = calc_nchunk(AW, CPA_CHUNK);
    localparam int unsigned PW   = NCH * CPA_CHUNK;
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;

    acc_state_t state_q, state_d;

    logic [AW-1:0]        s_q, c_q;
    logic [CW-1:0]        cnt_q;
    logic                 cin_q;
    logic [AW-1:0]        out_q;

    logic [AW-1:0]        row_s [NUM_IN+1];
    logic [AW-1:0]        row_c [NUM_IN+1];

    logic [PW-1:0]        s_pad, c_pad;
    logic [CPA_CHUNK-1:0] s_chunk, c_chunk;
    logic [CPA_CHUNK:0]   chunk_sum;
    logic                 last_chunk;

    // Chained compressor rows fold every operand of a beat into (S, C).
    assign row_s[0] = s_q;
    assign row_c[0] = c_q;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_rows
        csa_row #(.W(AW)) u_row (
            .a     (row_s[k]),
            .b     (row_c[k]),
            .c     (AW'(in_data[k*IN_W +: IN_W])),
            .sum   (row_s[k+1]),
            .carry (row_c[k+1])
        );
    end

    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_q;
    assign last_chunk = (cnt_q == CW'(NCH - 1));

    always_comb begin
        s_pad     = PW'(s_q);
        c_pad     = PW'(c_q);
        s_chunk   = s_pad[32'(cnt_q) * CPA_CHUNK +: CPA_CHUNK];
        c_chunk   = c_pad[32'(cnt_q) * CPA_CHUNK +: CPA_CHUNK];
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CPA_CHUNK + 1)'(cin_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (in_valid && in_last) state_d = RESOLVE;
            RESOLVE: if (last_chunk)          state_d = DONE;
            DONE:    if (out_ready)           state_d = ACC;
            default:                          state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ACC;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
            cin_q <= 1'b0;
            out_q <= '0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (in_valid) begin
                        s_q <= row_s[NUM_IN];
                        c_q <= row_c[NUM_IN];
                        if (in_last) begin
                            cnt_q <= '0;
                            cin_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    // Bits past AW in the top chunk, and its carry-out, are simply never stored.
                    for (int unsigned i = 0; i < AW; i++) begin
                        if ((i / CPA_CHUNK) == 32'(cnt_q))
                            out_q[i] <= chunk_sum[i % CPA_CHUNK];
                    end
                    cin_q <= chunk_sum[CPA_CHUNK];
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        s_q <= '0;
                        c_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator against a plain-arithmetic running-sum model.
module tb_csa_accumulator;

    localparam int unsigned IN_W   = 128;
    localparam int unsigned NUM_IN = 2;
    localparam int unsigned GUARD  = 8;
    localparam int unsigned CHUNK  = 32;
    localparam int unsigned AW     = IN_W + GUARD;
    localparam int unsigned NCH    = (AW + CHUNK - 1) / CHUNK;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_IN*IN_W-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [AW-1:0]          out_data;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [AW-1:0] model_acc;
    logic [AW-1:0] model_result;

    always #5 clk = ~clk;

    csa_accumulator #(
        .IN_W      (IN_W),
        .NUM_IN    (NUM_IN),
        .GUARD     (GUARD),
        .CPA_CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd_op();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for acceptance, and fold it into the model.
    task automatic send_beat(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = {b, a};
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_timeout", AW'(n < 50), AW'(1));
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        model_acc = model_acc + AW'(a) + AW'(b);
        if (last) begin
            model_result = model_acc;
            model_acc    = '0;
        end
    endtask

    // Called right after the last beat's accept edge; checks latency and data.
    task automatic wait_result(input string tag, input logic [AW-1:0] exp, input bit handshake);
        int n = 0;
        while (!out_valid && n < 40) begin
            check({tag, "_in_ready_low"}, AW'(in_ready), AW'(0));
            tick();
            n++;
        end
        check({tag, "_latency"}, AW'(n), AW'(NCH));
        check({tag, "_data"}, out_data, exp);
        if (handshake) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_in_ready_back"}, AW'(in_ready), AW'(1));
        end
    endtask

    initial begin
        logic [IN_W-1:0] ones;
        logic [AW-1:0]   held;
        int unsigned     beats;

        ones      = '1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_acc = '0;
        model_result = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_in_ready", AW'(in_ready), AW'(1));
        check("reset_out_valid", AW'(out_valid), AW'(0));
        check("reset_out_data", out_data, '0);

        // Single beat 5 + 7.
        send_beat(128'd5, 128'd7, 1'b1);
        wait_result("single", AW'(12), 1'b1);
        check("single_model", model_result, AW'(12));

        // Three beats of all-ones operands: 6*2^128 - 6.
        for (int i = 0; i < 3; i++) send_beat(ones, ones, i == 2);
        wait_result("three_max", (AW'(6) << 128) - AW'(6), 1'b1);

        // Carry across the chunk 0/1 boundary.
        send_beat(128'hFFFF_FFFF, 128'd1, 1'b1);
        wait_result("chunk_carry", AW'(1) << 32, 1'b1);

        // 256 all-ones beats wrap modulo 2^136.
        for (int i = 0; i < 256; i++) send_beat(ones, ones, i == 255);
        wait_result("wrap", '1 - AW'(511), 1'b1);
        check("wrap_model", model_result, '1 - AW'(511));

        // Random accumulations with random idle gaps.
        for (int t = 0; t < 6; t++) begin
            beats = $urandom_range(1, 8);
            for (int unsigned i = 0; i < beats; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(rnd_op(), rnd_op(), i == beats - 1);
            end
            wait_result("random", model_result, 1'b1);
        end

        // Backpressure in DONE with a beat offered: nothing may be consumed.
        send_beat(rnd_op(), rnd_op(), 1'b1);
        wait_result("bp", model_result, 1'b0);
        held     = model_result;
        in_valid = 1'b1;
        in_data  = {rnd_op(), rnd_op()};
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data_stable", out_data, held);
            check("bp_in_ready", AW'(in_ready), AW'(0));
            check("bp_out_valid", AW'(out_valid), AW'(1));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_in_ready", AW'(in_ready), AW'(1));
        send_beat(128'd3, 128'd4, 1'b1);
        wait_result("bp_fresh", AW'(7), 1'b1);

        // out_ready held high in advance: DONE lasts one cycle.
        out_ready = 1'b1;
        send_beat(128'd9, 128'd10, 1'b1);
        repeat (NCH) tick();
        check("early_ready_valid", AW'(out_valid), AW'(1));
        check("early_ready_data", out_data, AW'(19));
        tick();
        check("early_ready_back", AW'(in_ready), AW'(1));
        out_ready = 1'b0;

        // Reset during RESOLVE chunk 2 aborts the sum.
        send_beat(ones, rnd_op(), 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", AW'(out_valid), AW'(0));
        check("abort_in_ready", AW'(in_ready), AW'(1));
        check("abort_out_data", out_data, '0);
        send_beat(128'd1, 128'd1, 1'b1);
        wait_result("after_abort", AW'(2), 1'b1);

        // Zero-operand last beat returns the prior accumulation.
        send_beat(128'd100, 128'd23, 1'b0);
        send_beat(128'd0, 128'd0, 1'b1);
        wait_result("zero_last", AW'(123), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
